// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: default widths, depth and word/pointer/count types for the RAM FIFO controller
package ram_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEPTH = 2 ** DEF_ADDR_WIDTH;
  typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;
  typedef logic [DEF_ADDR_WIDTH:0] cnt_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: valid/ready push and pop streams of the RAM FIFO controller
interface ram_fifo_ctrl_if import ram_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [DATA_WIDTH-1:0] in_data, out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-port-RAM FIFO controller with registered output stage.
// Define RAM_FIFO_HWM_EN to add the hwm (max count since reset) port.
module ram_fifo_ctrl import ram_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef RAM_FIFO_HWM_EN
  output logic [ADDR_WIDTH:0]   hwm,
`endif
  ram_fifo_ctrl_if.slave        s,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int DEPTH_P = 2 ** ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] count_nxt;
  logic rd_go, wr_go;
  // reads take the shared address first; a write only happens on a cycle with no read
  always_comb begin
    rd_go = (count != '0) && (!s.out_valid || s.out_ready);
    full = count == (ADDR_WIDTH+1)'(DEPTH_P);
    empty = (count == '0) && !s.out_valid;
    s.in_ready = !reset && !full && !rd_go;
    wr_go = s.in_valid && s.in_ready;
    ram_we = wr_go;
    ram_addr = rd_go ? rd_ptr : wr_ptr;
    ram_d = s.in_data;
    count_nxt = count + (ADDR_WIDTH+1)'(wr_go) - (ADDR_WIDTH+1)'(rd_go);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      s.out_valid <= 1'b0;
      s.out_data <= '0;
    end else begin
      count <= count_nxt;
      if (wr_go) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) begin
        s.out_data <= ram_q;
        s.out_valid <= 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
      end else if (s.out_valid && s.out_ready) begin
        s.out_valid <= 1'b0;
      end
    end
  end
`ifdef RAM_FIFO_HWM_EN
  always_ff @(posedge clk) begin
    if (reset) hwm <= '0;
    else if (count_nxt > hwm) hwm <= count_nxt;
  end
`endif
endmodule
